// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of the 16-bit pipeline. It sits directly after the registered
//   ALU and takes the ALU result in one of two ways: as a word address for a
//   load/store, or as a value passed straight through to WB. Each memory
//   instruction runs one data-memory transaction over a req/ack handshake.
//   While that transaction is pending, the stage holds off EX.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   ex_valid/ready    EX handshake (ready is combinational, high only in IDLE)
//   ex_alu_res        address for loads/stores, result for pass-through ops
//   ex_st_data        store data
//   ex_mem_rd/wr      load / store select (both set is illegal)
//   ex_rd, ex_reg_wr  destination register and its write enable
//   dmem_*            registered memory request side; ack is a 1-cycle pulse
//   wb_*              1-cycle result pulse to WB; data/rd hold between pulses
//   err_clr, bus_err  sticky error (timeout or illegal op) and its clear
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_wr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_wr,
  input  logic              err_clr,
  output logic              bus_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // The last wait cycle: if ack is still missing when the counter sits here,
  // the coming edge takes it to TIMEOUT and aborts the access.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [REG_AW-1:0]   accRd_q, accRd_d;
  logic                accRegWr_q, accRegWr_d;
  logic                wbValid_q, wbValid_d;
  logic [DATA_W-1:0]   wbData_q, wbData_d;
  logic [REG_AW-1:0]   wbRd_q, wbRd_d;
  logic                wbRegWr_q, wbRegWr_d;
  logic                busErr_q, busErr_d;
  logic                accept;

  assign ex_ready = (state_q == IDLE);
  assign accept   = ex_valid && ex_ready;

  // Next-state logic. Every branch that raises bus_err comes after the
  // err_clr default, so a new error wins over a clear in the same cycle.
  // The memory-side registers keep their values for the whole access.
  // This keeps dmem_* stable until ack without needing extra enables.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    accRd_d    = accRd_q;
    accRegWr_d = accRegWr_q;
    wbValid_d  = 1'b0;
    wbData_d   = wbData_q;
    wbRd_d     = wbRd_q;
    wbRegWr_d  = wbRegWr_q;
    busErr_d   = busErr_q && !err_clr;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (ex_mem_rd && ex_mem_wr) begin
            busErr_d  = 1'b1;
            wbValid_d = 1'b1;
            wbData_d  = ex_alu_res;
            wbRd_d    = ex_rd;
            wbRegWr_d = 1'b0;
          end else if (ex_mem_rd || ex_mem_wr) begin
            state_d    = ACCESS;
            cnt_d      = 8'd0;
            req_d      = 1'b1;
            we_d       = ex_mem_wr;
            addr_d     = ex_alu_res;
            wdata_d    = ex_st_data;
            accRd_d    = ex_rd;
            accRegWr_d = ex_reg_wr;
          end else begin
            wbValid_d = 1'b1;
            wbData_d  = ex_alu_res;
            wbRd_d    = ex_rd;
            wbRegWr_d = ex_reg_wr;
          end
        end
      end

      ACCESS: begin
        if (dmem_ack) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          wbValid_d = 1'b1;
          wbRd_d    = accRd_q;
          if (we_q) begin
            wbData_d  = addr_q;
            wbRegWr_d = 1'b0;
          end else begin
            wbData_d  = dmem_rdata;
            wbRegWr_d = accRegWr_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TIMEOUT_LAST) begin
            state_d   = IDLE;
            req_d     = 1'b0;
            busErr_d  = 1'b1;
            wbValid_d = 1'b1;
            wbData_d  = addr_q;
            wbRd_d    = accRd_q;
            wbRegWr_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers. An asynchronous reset drops any in-flight
  // request at once and never produces a WB pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      accRd_q    <= '0;
      accRegWr_q <= 1'b0;
      wbValid_q  <= 1'b0;
      wbData_q   <= '0;
      wbRd_q     <= '0;
      wbRegWr_q  <= 1'b0;
      busErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      accRd_q    <= accRd_d;
      accRegWr_q <= accRegWr_d;
      wbValid_q  <= wbValid_d;
      wbData_q   <= wbData_d;
      wbRd_q     <= wbRd_d;
      wbRegWr_q  <= wbRegWr_d;
      busErr_q   <= busErr_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wbValid_q;
  assign wb_data    = wbData_q;
  assign wb_rd      = wbRd_q;
  assign wb_reg_wr  = wbRegWr_q;
  assign bus_err    = busErr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Directed bench for mem_access_stage. Each scenario task drives its own
//   stimulus and checks the results against hand-computed values.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_alu_res;
  logic [15:0] ex_st_data;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [2:0]  ex_rd;
  logic        ex_reg_wr;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_reg_wr;
  logic        err_clr;
  logic        bus_err;

  int testsRun    = 0;
  int testsFailed = 0;

  mem_access_stage #(.DATA_W(16), .REG_AW(3), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_alu_res (ex_alu_res),
    .ex_st_data (ex_st_data),
    .ex_mem_rd  (ex_mem_rd),
    .ex_mem_wr  (ex_mem_wr),
    .ex_rd      (ex_rd),
    .ex_reg_wr  (ex_reg_wr),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_reg_wr  (wb_reg_wr),
    .err_clr    (err_clr),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step one cycle and settle 1 ns past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    ex_valid   = 1'b0;
    ex_alu_res = 16'h0000;
    ex_st_data = 16'h0000;
    ex_mem_rd  = 1'b0;
    ex_mem_wr  = 1'b0;
    ex_rd      = 3'd0;
    ex_reg_wr  = 1'b0;
    dmem_rdata = 16'h0000;
    dmem_ack   = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 1'b0;
    #12;
    testsRun++;
    if ({dmem_req, wb_valid, bus_err, wb_reg_wr} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_outs got req/wbv/err/rw=%b exp 0000",
               {dmem_req, wb_valid, bus_err, wb_reg_wr});
    end
    testsRun++;
    if (wb_data !== 16'h0000 || ex_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_data got wb_data=%h ready=%b exp 0000 1", wb_data, ex_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pass_through();
    ex_valid = 1'b1; ex_alu_res = 16'h003C; ex_rd = 3'd3; ex_reg_wr = 1'b1;
    tick();
    idleInputs();
    testsRun++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h003C || wb_rd !== 3'd3 || wb_reg_wr !== 1'b1 || ex_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pass_through got v=%b d=%h rd=%0d rw=%b rdy=%b exp 1 003c 3 1 1",
               wb_valid, wb_data, wb_rd, wb_reg_wr, ex_ready);
    end
    tick();
    testsRun++;
    if (wb_valid !== 1'b0 || wb_data !== 16'h003C || dmem_req !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pass_hold got v=%b d=%h req=%b exp 0 003c 0", wb_valid, wb_data, dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1'b1; ex_alu_res = 16'h1111; ex_rd = 3'd1; ex_reg_wr = 1'b1;
    tick();
    ex_alu_res = 16'h2222; ex_rd = 3'd6; ex_reg_wr = 1'b0;
    testsRun++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h1111 || wb_rd !== 3'd1 || wb_reg_wr !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first got v=%b d=%h rd=%0d rw=%b exp 1 1111 1 1",
               wb_valid, wb_data, wb_rd, wb_reg_wr);
    end
    tick();
    idleInputs();
    testsRun++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h2222 || wb_rd !== 3'd6 || wb_reg_wr !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second got v=%b d=%h rd=%0d rw=%b exp 1 2222 6 0",
               wb_valid, wb_data, wb_rd, wb_reg_wr);
    end
    tick();
  endtask

  task automatic test_load();
    int reqCycles;
    reqCycles = 0;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_res = 16'h0010; ex_rd = 3'd5; ex_reg_wr = 1'b1;
    tick();
    idleInputs();
    testsRun++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 16'h0010 || ex_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL load_req got req=%b we=%b addr=%h rdy=%b exp 1 0 0010 0",
               dmem_req, dmem_we, dmem_addr, ex_ready);
    end
    for (int i = 0; i < 3; i++) begin
      if (dmem_req === 1'b1 && ex_ready === 1'b0 && wb_valid === 1'b0) reqCycles++;
      if (i == 2) begin
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
      end else begin
        tick();
      end
    end
    tick();
    dmem_ack = 1'b0; dmem_rdata = 16'h0000;
    testsRun++;
    if (reqCycles !== 3) begin
      testsFailed++;
      $display("[TB] FAIL load_wait got %0d stalled req cycles exp 3", reqCycles);
    end
    testsRun++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 16'hBEEF || wb_rd !== 3'd5 ||
        wb_reg_wr !== 1'b1 || ex_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL load_wb got req=%b v=%b d=%h rd=%0d rw=%b rdy=%b exp 0 1 beef 5 1 1",
               dmem_req, wb_valid, wb_data, wb_rd, wb_reg_wr, ex_ready);
    end
    tick();
  endtask

  task automatic test_store();
    ex_valid = 1'b1; ex_mem_wr = 1'b1; ex_alu_res = 16'h0020; ex_st_data = 16'h1234;
    ex_rd = 3'd4; ex_reg_wr = 1'b1;
    tick();
    idleInputs();
    testsRun++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 16'h0020 || dmem_wdata !== 16'h1234) begin
      testsFailed++;
      $display("[TB] FAIL store_req got req=%b we=%b addr=%h wd=%h exp 1 1 0020 1234",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 16'h0000;
    testsRun++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wb_reg_wr !== 1'b0 || wb_data !== 16'h0020) begin
      testsFailed++;
      $display("[TB] FAIL store_wb got req=%b v=%b rw=%b d=%h exp 0 1 0 0020",
               dmem_req, wb_valid, wb_reg_wr, wb_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    int reqCycles;
    reqCycles = 0;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_res = 16'h0030; ex_rd = 3'd2; ex_reg_wr = 1'b1;
    tick();
    idleInputs();
    while (dmem_req === 1'b1 && reqCycles < 40) begin
      reqCycles++;
      tick();
    end
    testsRun++;
    if (reqCycles !== 15) begin
      testsFailed++;
      $display("[TB] FAIL timeout_len got %0d req cycles exp 15", reqCycles);
    end
    testsRun++;
    if (dmem_req !== 1'b0 || bus_err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_wr !== 1'b0 || ex_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL timeout_abort got req=%b err=%b v=%b rw=%b rdy=%b exp 0 1 1 0 1",
               dmem_req, bus_err, wb_valid, wb_reg_wr, ex_ready);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    testsRun++;
    if (bus_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_clr got bus_err=%b exp 0", bus_err);
    end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_res = 16'h0031; ex_rd = 3'd7; ex_reg_wr = 1'b1;
    tick();
    idleInputs();
    for (int i = 0; i < 14; i++) tick();
    testsRun++;
    if (dmem_req !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ack_edge_req got req=%b exp 1 in 15th wait cycle", dmem_req);
    end
    dmem_ack = 1'b1; dmem_rdata = 16'h5A5A;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 16'h0000;
    testsRun++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h5A5A || wb_rd !== 3'd7 || wb_reg_wr !== 1'b1 || bus_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ack_wins got v=%b d=%h rd=%0d rw=%b err=%b exp 1 5a5a 7 1 0",
               wb_valid, wb_data, wb_rd, wb_reg_wr, bus_err);
    end
    tick();
  endtask

  task automatic test_illegal();
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b1; ex_alu_res = 16'h0040; ex_rd = 3'd2; ex_reg_wr = 1'b1;
    tick();
    idleInputs();
    testsRun++;
    if (dmem_req !== 1'b0 || bus_err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_wr !== 1'b0 || ex_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL illegal got req=%b err=%b v=%b rw=%b rdy=%b exp 0 1 1 0 1",
               dmem_req, bus_err, wb_valid, wb_reg_wr, ex_ready);
    end
    dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 16'h0000;
    testsRun++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1 || wb_data !== 16'h0040) begin
      testsFailed++;
      $display("[TB] FAIL idle_ack got v=%b req=%b rdy=%b d=%h exp 0 0 1 0040",
               wb_valid, dmem_req, ex_ready, wb_data);
    end
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b1; err_clr = 1'b1;
    tick();
    idleInputs();
    testsRun++;
    if (bus_err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL err_set_prio got bus_err=%b exp 1", bus_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    testsRun++;
    if (bus_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_clr2 got bus_err=%b exp 0", bus_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    int wbPulses;
    wbPulses = 0;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_alu_res = 16'h0050; ex_rd = 3'd1; ex_reg_wr = 1'b1;
    tick();
    idleInputs();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset got req=%b v=%b exp 0 0", dmem_req, wb_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wb_valid !== 1'b0) wbPulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (wb_valid !== 1'b0) wbPulses++;
    end
    testsRun++;
    if (wbPulses !== 0 || ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_quiet got pulses=%0d rdy=%b req=%b exp 0 1 0", wbPulses, ex_ready, dmem_req);
    end
    ex_valid = 1'b1; ex_alu_res = 16'h0077; ex_rd = 3'd6; ex_reg_wr = 1'b1;
    tick();
    idleInputs();
    testsRun++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h0077 || wb_rd !== 3'd6 || wb_reg_wr !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_pass got v=%b d=%h rd=%0d rw=%b exp 1 0077 6 1",
               wb_valid, wb_data, wb_rd, wb_reg_wr);
    end
    tick();
  endtask

  // Scenario sequence; each task leaves the stage idle for the next one.
  initial begin
    test_reset();
    test_pass_through();
    test_back_to_back();
    test_load();
    test_store();
    test_timeout();
    test_ack_at_timeout();
    test_illegal();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
